// File: rtl/pdc_pkg.sv
// Shared types and helpers for the processor debug controller.
package pdc_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    // Operating modes as driven on the Mode input.
    typedef enum logic [1:0] {
        MODE_STEP  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_BURST = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_t;

    // Hex nibble to active-low 7-segment glyph, segment a in the MSB, g in the LSB.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0: lit = 7'b1111110;
            4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;
            4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;
            4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;
            4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;
            4'h9: lit = 7'b1111011;
            4'hA: lit = 7'b1110111;
            4'hB: lit = 7'b0011111;
            4'hC: lit = 7'b1001110;
            4'hD: lit = 7'b0111101;
            4'hE: lit = 7'b1001111;
            default: lit = 7'b1000111;
        endcase
        return ~lit;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-flop synchronizer, level debouncer and
// press-edge detector producing a one-cycle pulse on released->pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int            CW      = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the asynchronous key into the clk domain; idles at released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], key_n};
    end

    // Accept a new level after DEBOUNCE_CYC consecutive cycles away from the
    // current one; flag a press when the accepted level falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync[1];
                cnt   <= '0;
                press <= level;     // old level released -> new level pressed
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/proc_debug_ctrl.sv
// Processor debug controller: single-step / run / burst clock-enable
// generation from a push-button, step counter and a channel display
// with 7-segment decode.
module proc_debug_ctrl
    import pdc_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int DATA_W       = 16,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int RUN_DIV      = 25000000
) (
    input  logic                        Clk,
    input  logic                        ResetN,
    input  logic                        StepKeyN,
    input  logic [1:0]                  Mode,
    input  logic [7:0]                  BurstLen,
    input  logic [$clog2(NUM_CH)-1:0]   Sel,
    input  logic [NUM_CH*DATA_W-1:0]    ChData,
    input  logic                        Freeze,
    output logic                        StepEn,
    output logic                        Busy,
    output logic [DATA_W-1:0]           DispVal,
    output logic [(DATA_W/4)*7-1:0]     HexSeg,
    output logic [15:0]                 StepCount
);

    localparam int               DIGITS  = DATA_W / 4;
    localparam int               DIV_W   = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    state_t              state;
    mode_t               mode;
    logic                press;
    logic [DIV_W-1:0]    div_cnt;
    logic [7:0]          burst_cnt;
    logic                burst_phase;
    logic                step_en;
    logic [DATA_W-1:0]   sel_data;

    assign mode   = mode_t'(Mode);
    assign StepEn = step_en;
    assign Busy   = (state == ST_BURST);

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key (
        .clk   (Clk),
        .rst_n (ResetN),
        .key_n (StepKeyN),
        .press (press)
    );

    // Step-generation FSM; any Mode change out of RUN/PAUSE/BURST aborts to IDLE.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state       <= ST_IDLE;
            div_cnt     <= '0;
            burst_cnt   <= '0;
            burst_phase <= 1'b0;
            step_en     <= 1'b0;
        end else begin
            step_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    div_cnt <= '0;
                    if (mode == MODE_RUN) begin
                        state <= ST_RUN;
                    end else if (press && mode == MODE_STEP) begin
                        step_en <= 1'b1;
                    end else if (press && mode == MODE_BURST && BurstLen != 8'd0) begin
                        state       <= ST_BURST;
                        burst_cnt   <= BurstLen;
                        burst_phase <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (mode != MODE_RUN) begin
                        state   <= ST_IDLE;
                        div_cnt <= '0;
                    end else if (press) begin
                        state   <= ST_PAUSE;
                        div_cnt <= '0;
                    end else if (div_cnt == DIV_MAX) begin
                        div_cnt <= '0;
                        step_en <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (mode != MODE_RUN) begin
                        state <= ST_IDLE;
                    end else if (press) begin
                        state   <= ST_RUN;
                        div_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    // Pulse on even phases, leave once the count is spent.
                    if (mode != MODE_BURST) begin
                        state       <= ST_IDLE;
                        burst_cnt   <= '0;
                        burst_phase <= 1'b0;
                    end else if (!burst_phase) begin
                        step_en     <= 1'b1;
                        burst_cnt   <= burst_cnt - 8'd1;
                        burst_phase <= 1'b1;
                    end else begin
                        burst_phase <= 1'b0;
                        if (burst_cnt == 8'd0) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Total issued steps, wrapping naturally at 16 bits.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)      StepCount <= '0;
        else if (step_en) StepCount <= StepCount + 16'd1;
    end

    // Channel mux; unmapped select values fall back to channel 0.
    always_comb begin
        // NOTE: default first so every path assigns sel_data and no latch is inferred.
        sel_data = ChData[DATA_W-1:0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (32'(Sel) == k) sel_data = ChData[k*DATA_W +: DATA_W];
        end
    end

    // Display register, held while Freeze is high.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)      DispVal <= '0;
        else if (!Freeze) DispVal <= sel_data;
    end

    // Per-nibble 7-segment decode of the displayed value.
    always_comb begin
        HexSeg = '0;
        for (int d = 0; d < DIGITS; d++) begin
            HexSeg[d*7 +: 7] = hex_to_seg(DispVal[d*4 +: 4]);
        end
    end

endmodule

// File: tb/tb_proc_debug_ctrl.sv
// Directed self-checking bench for proc_debug_ctrl (NUM_CH=4, DATA_W=16,
// DEBOUNCE_CYC=4, RUN_DIV=5) plus a NUM_CH=5 instance for out-of-range Sel.
module tb_proc_debug_ctrl;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        StepKeyN;
    logic [1:0]  Mode;
    logic [7:0]  BurstLen;
    logic [1:0]  Sel;
    logic [63:0] ChData;
    logic        Freeze;
    logic        StepEn;
    logic        Busy;
    logic [15:0] DispVal;
    logic [27:0] HexSeg;
    logic [15:0] StepCount;

    logic [2:0]  sel5;
    logic [79:0] ch_data5;
    logic        o_step_en;
    logic        o_busy;
    logic [15:0] o_disp;
    logic [27:0] o_hex;
    logic [15:0] o_count;

    int tests = 0;
    int fails = 0;

    proc_debug_ctrl #(
        .NUM_CH(4), .DATA_W(16), .DEBOUNCE_CYC(4), .RUN_DIV(5)
    ) dut (
        .Clk(Clk), .ResetN(ResetN), .StepKeyN(StepKeyN), .Mode(Mode),
        .BurstLen(BurstLen), .Sel(Sel), .ChData(ChData), .Freeze(Freeze),
        .StepEn(StepEn), .Busy(Busy), .DispVal(DispVal), .HexSeg(HexSeg),
        .StepCount(StepCount)
    );

    proc_debug_ctrl #(
        .NUM_CH(5), .DATA_W(16), .DEBOUNCE_CYC(4), .RUN_DIV(5)
    ) dut_oor (
        .Clk(Clk), .ResetN(ResetN), .StepKeyN(StepKeyN), .Mode(Mode),
        .BurstLen(BurstLen), .Sel(sel5), .ChData(ch_data5), .Freeze(Freeze),
        .StepEn(o_step_en), .Busy(o_busy), .DispVal(o_disp), .HexSeg(o_hex),
        .StepCount(o_count)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the key pressed for 10 cycles then released for 10; mask bit i
    // records StepEn sampled after the i-th edge (the key is first seen low at edge 1).
    task automatic press_key(output logic [31:0] mask, output int busy_n);
        mask   = '0;
        busy_n = 0;
        StepKeyN = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (StepEn) mask[i] = 1'b1;
            if (Busy)   busy_n++;
            if (i == 10) StepKeyN = 1'b1;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mask;
        int          busy_n;
        int          n;
        int          k;
        int          tot;
        int          timeouts;

        ResetN   = 1'b0;
        StepKeyN = 1'b1;
        Mode     = 2'b00;
        BurstLen = 8'd0;
        Sel      = 2'd0;
        ChData   = '0;
        Freeze   = 1'b0;
        sel5     = 3'd0;
        ch_data5 = '0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_step_en",  StepEn,    0);
        check("rst_busy",     Busy,      0);
        check("rst_disp",     DispVal,   0);
        check("rst_count",    StepCount, 0);
        check("rst_hex",      HexSeg,    {4{7'h01}});
        check("rst_oor_out",  {o_step_en, o_busy, o_count, o_hex}, {2'b00, 16'h0, {4{7'h01}}});
        @(negedge Clk);
        ResetN = 1'b1;
        tick();

        // Single-step: a 2-cycle glitch is rejected, a long press gives one step
        StepKeyN = 1'b0;
        tick();
        tick();
        StepKeyN = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (StepEn) n++;
        end
        check("step_glitch", n, 0);
        press_key(mask, busy_n);
        check("step_press_mask", mask, 32'h0000_0080);
        check("step_count_1", StepCount, 16'd1);

        // Hold mode never steps
        Mode = 2'b11;
        press_key(mask, busy_n);
        check("hold_mask", mask, 32'h0);

        // Run: entry on edge 1, pulses on edges 6,11,16,21
        Mode = 2'b01;
        mask = '0;
        for (int i = 1; i <= 23; i++) begin
            tick();
            if (StepEn) mask[i] = 1'b1;
        end
        check("run_mask", mask, 32'h0021_0840);
        // divider is at 2 here, so one more pulse lands before the pause takes effect
        press_key(mask, busy_n);
        check("pause_press_mask", mask, 32'h0000_0008);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (StepEn) n++;
        end
        check("pause_quiet", n, 0);
        press_key(mask, busy_n);
        check("resume_mask", mask, 32'h0002_1000);
        Mode = 2'b00;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (StepEn) n++;
        end
        check("run_abort_quiet", n, 0);
        check("count_after_run", StepCount, 16'd8);

        // Burst of 3: entry on edge 7, pulses on edges 8,10,12, Busy for 6 cycles
        Mode     = 2'b10;
        BurstLen = 8'd3;
        press_key(mask, busy_n);
        check("burst3_mask", mask, 32'h0000_1500);
        check("burst3_busy", busy_n, 6);
        check("count_after_burst", StepCount, 16'd11);

        // BurstLen of zero never enters BURST
        BurstLen = 8'd0;
        press_key(mask, busy_n);
        check("burst0_mask", mask, 32'h0);
        check("burst0_busy", busy_n, 0);

        // Burst of 200 aborted by a Mode change after the fourth pulse
        BurstLen = 8'd200;
        StepKeyN = 1'b0;
        n = 0;
        k = 0;
        while (n < 4 && k < 60) begin
            tick();
            k++;
            if (StepEn) n++;
        end
        check("abort_reach4", n, 4);
        check("abort_busy_before", Busy, 1);
        Mode = 2'b00;
        tick();
        check("abort_busy_after", Busy, 0);
        check("abort_step_after", StepEn, 0);
        StepKeyN = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (StepEn) n++;
        end
        check("abort_quiet", n, 0);
        check("count_after_abort", StepCount, 16'd15);

        // Display path and 7-segment glyphs
        ChData = {16'h89AB, 16'hBEEF, 16'h4567, 16'h0123};
        Sel    = 2'd2;
        #1;
        check("disp_latency", DispVal, 16'h0000);
        tick();
        check("disp_beef", DispVal, 16'hBEEF);
        check("hex_beef", HexSeg, {7'h60, 7'h30, 7'h30, 7'h38});
        Freeze = 1'b1;
        ChData[47:32] = 16'h1234;
        tick();
        tick();
        tick();
        check("disp_frozen", DispVal, 16'hBEEF);
        Freeze = 1'b0;
        tick();
        check("disp_unfrozen", DispVal, 16'h1234);
        check("hex_1234", HexSeg, {7'h4F, 7'h12, 7'h06, 7'h4C});
        Sel = 2'd0;
        tick();
        check("hex_0123", HexSeg, {7'h01, 7'h4F, 7'h12, 7'h06});
        Sel = 2'd1;
        tick();
        check("hex_4567", HexSeg, {7'h4C, 7'h24, 7'h20, 7'h0F});
        Sel = 2'd3;
        tick();
        check("hex_89ab", HexSeg, {7'h00, 7'h04, 7'h08, 7'h60});
        ChData[47:32] = 16'hCDEF;
        Sel = 2'd2;
        tick();
        check("hex_cdef", HexSeg, {7'h31, 7'h42, 7'h30, 7'h38});

        // Out-of-range select on the 5-channel instance falls back to channel 0
        ch_data5 = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'hC0DE};
        sel5 = 3'd5;
        tick();
        check("oor_sel5", o_disp, 16'hC0DE);
        sel5 = 3'd4;
        tick();
        check("oor_sel4", o_disp, 16'h4444);
        sel5 = 3'd7;
        tick();
        check("oor_sel7", o_disp, 16'hC0DE);

        // Reset asserted mid-burst cuts StepEn and Busy immediately
        Mode     = 2'b10;
        BurstLen = 8'd200;
        StepKeyN = 1'b0;
        n = 0;
        k = 0;
        while (n < 2 && k < 40) begin
            tick();
            k++;
            if (StepEn) n++;
        end
        check("rst_mid_reach", {31'd0, StepEn}, 1);
        #2;
        ResetN = 1'b0;
        #1;
        check("rst_mid_step", StepEn, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_count", StepCount, 0);
        StepKeyN = 1'b1;
        @(negedge Clk);
        ResetN = 1'b1;
        #1;
        check("rst_rel_busy", Busy, 0);
        tick();
        check("rst_rel_busy_edge", Busy, 0);
        check("rst_rel_step_edge", StepEn, 0);

        // Wrap: 257 bursts of 255 reach 16'hFFFF, one more step wraps to 0
        BurstLen = 8'd255;
        tot      = 0;
        timeouts = 0;
        for (int b = 0; b < 257; b++) begin
            StepKeyN = 1'b0;
            k = 0;
            while (!Busy && k < 20) begin
                tick();
                k++;
                if (StepEn) tot++;
            end
            if (!Busy) timeouts++;
            StepKeyN = 1'b1;
            k = 0;
            while (Busy && k < 600) begin
                tick();
                k++;
                if (StepEn) tot++;
            end
            if (Busy) timeouts++;
        end
        check("wrap_timeouts", timeouts, 0);
        check("wrap_pulses", tot, 65535);
        check("wrap_count_ffff", StepCount, 16'hFFFF);
        Mode = 2'b00;
        press_key(mask, busy_n);
        check("wrap_step_mask", mask, 32'h0000_0080);
        check("wrap_count_0", StepCount, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
